// File: rtl/hdlverifier_capture_pkg.sv
// Shared types for the capture sequencer: state enum, debug encodings, depth helper.
package hdlverifier_capture_pkg;

  localparam logic [2:0] ENC_IDLE      = 3'd0;
  localparam logic [2:0] ENC_PRETRIG   = 3'd1;
  localparam logic [2:0] ENC_WAIT_TRIG = 3'd2;
  localparam logic [2:0] ENC_POSTTRIG  = 3'd3;
  localparam logic [2:0] ENC_DONE      = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = ENC_IDLE,
    ST_PRETRIG   = ENC_PRETRIG,
    ST_WAIT_TRIG = ENC_WAIT_TRIG,
    ST_POSTTRIG  = ENC_POSTTRIG,
    ST_DONE      = ENC_DONE
  } capture_state_t;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/hdlverifier_capture_addr_gen.sv
// Write-address and window-counter datapath; all arithmetic wraps modulo DEPTH.
module hdlverifier_capture_addr_gen
  import hdlverifier_capture_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  input  logic                  load,
  input  logic                  write,
  input  logic                  post_load,
  input  logic [ADDR_WIDTH-1:0] pos,
  input  logic [ADDR_WIDTH-1:0] load_cnt,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] cnt,
  output logic [ADDR_WIDTH-1:0] window_start,
  output logic [ADDR_WIDTH-1:0] post_cnt
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Post-trigger writes still owed after the trigger sample itself.
  assign post_cnt     = LAST - pos;
  assign window_start = wr_addr - pos;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr <= '0;
      cnt     <= '0;
    end else if (clk_enable) begin
      if (load) begin
        wr_addr <= '0;
        cnt     <= load_cnt;
      end else if (write) begin
        wr_addr <= wr_addr + ONE;
        if (post_load)
          cnt <= post_cnt;
        else if (cnt != '0)
          cnt <= cnt - ONE;
      end
    end
  end

endmodule

// File: rtl/hdlverifier_capture_ctrl.sv
// Capture sequencer: pre-trigger fill, trigger wait, post-trigger fill, window report.
// Optional macro HDLVERIFIER_CAPTURE_FORCE_TRIGGER_EN adds a force_trigger input.
module hdlverifier_capture_ctrl
  import hdlverifier_capture_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trigger,
`ifdef HDLVERIFIER_CAPTURE_FORCE_TRIGGER_EN
  input  logic                  force_trigger,
`endif
  input  logic [ADDR_WIDTH-1:0] trigger_position,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] trigger_addr,
  output logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  busy,
  output logic                  capture_done,
  output capture_state_t        debug_state
);

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  capture_state_t        state_q, state_d;
  logic [ADDR_WIDTH-1:0] pos_q, cnt, window_start, post_cnt;
  logic                  arm_take, trig_take, trig_in, cnt_last;

  // Handshake: arm is a level request accepted on an enabled edge in IDLE/DONE
  // (no back-pressure beyond that); busy acts as the not-ready indication.
`ifdef HDLVERIFIER_CAPTURE_FORCE_TRIGGER_EN
  logic force_pending_q, force_pending_d;

  assign trig_in = trigger | force_trigger | force_pending_q;

  always_comb begin
    force_pending_d = force_pending_q;
    if (abort || arm_take || trig_take)
      force_pending_d = 1'b0;
    else if (state_q == ST_PRETRIG && force_trigger)
      force_pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      force_pending_q <= 1'b0;
    else if (clk_enable)
      force_pending_q <= force_pending_d;
  end
`else
  assign trig_in = trigger;
`endif

  assign cnt_last = (cnt <= ONE);

  always_comb begin
    state_d   = state_q;
    arm_take  = 1'b0;
    trig_take = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            arm_take = 1'b1;
            // trigger_position is ADDR_WIDTH wide, so it never exceeds DEPTH-1.
            state_d  = (trigger_position != '0) ? ST_PRETRIG : ST_WAIT_TRIG;
          end
        end
        ST_PRETRIG:   if (cnt_last) state_d = ST_WAIT_TRIG;
        ST_WAIT_TRIG: begin
          if (trig_in) begin
            trig_take = 1'b1;
            state_d   = (post_cnt != '0) ? ST_POSTTRIG : ST_DONE;
          end
        end
        ST_POSTTRIG:  if (cnt_last) state_d = ST_DONE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pos_q        <= '0;
      trigger_addr <= '0;
      start_addr   <= '0;
    end else if (clk_enable) begin
      state_q <= state_d;
      if (arm_take)
        pos_q <= trigger_position;
      if (trig_take) begin
        trigger_addr <= wr_addr;
        start_addr   <= window_start;
      end
    end
  end

  assign busy         = (state_q == ST_PRETRIG) || (state_q == ST_WAIT_TRIG) ||
                        (state_q == ST_POSTTRIG);
  assign capture_done = (state_q == ST_DONE);
  assign wr_en        = clk_enable & busy;
  assign debug_state  = state_q;

  hdlverifier_capture_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .clk_enable   (clk_enable),
    .load         (arm_take),
    .write        (busy),
    .post_load    (trig_take),
    .pos          (pos_q),
    .load_cnt     (trigger_position),
    .wr_addr      (wr_addr),
    .cnt          (cnt),
    .window_start (window_start),
    .post_cnt     (post_cnt)
  );

endmodule

// File: tb/tb_hdlverifier_capture_ctrl.sv
// Self-checking bench for hdlverifier_capture_ctrl at ADDR_WIDTH=4 (DEPTH=16).
module tb_hdlverifier_capture_ctrl;
  import hdlverifier_capture_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset, clk_enable, arm, abort, trigger;
  logic [AW-1:0] trigger_position;
  logic          wr_en, busy, capture_done;
  logic [AW-1:0] wr_addr, trigger_addr, start_addr;
  capture_state_t debug_state;
`ifdef HDLVERIFIER_CAPTURE_FORCE_TRIGGER_EN
  logic          force_trigger = 1'b0;
`endif

  always #5 clk = ~clk;

  hdlverifier_capture_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .clk_enable       (clk_enable),
    .arm              (arm),
    .abort            (abort),
    .trigger          (trigger),
`ifdef HDLVERIFIER_CAPTURE_FORCE_TRIGGER_EN
    .force_trigger    (force_trigger),
`endif
    .trigger_position (trigger_position),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .trigger_addr     (trigger_addr),
    .start_addr       (start_addr),
    .busy             (busy),
    .capture_done     (capture_done),
    .debug_state      (debug_state)
  );

  // ---------------- scoreboard ----------------
  int            pass_cnt = 0;
  int            total_cnt = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_a;
  int            write_cnt = 0, cyc = 0, last_wr_cyc = 0, done_cyc = 0;
  bit            done_seen, saw_pretrig, saw_post;

  always @(negedge clk) begin
    cyc++;
    if (debug_state == ST_PRETRIG)  saw_pretrig = 1'b1;
    if (debug_state == ST_POSTTRIG) saw_post = 1'b1;
    if (capture_done === 1'b1 && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    if (wr_en === 1'b1) begin
      write_cnt++;
      last_wr_cyc = cyc;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL wr_addr: unexpected write at address %0d, none expected", wr_addr);
      end else begin
        exp_a = exp_q.pop_front();
        if (wr_addr !== exp_a)
          $display("FAIL wr_addr: got %0d want %0d", wr_addr, exp_a);
        else
          pass_cnt++;
      end
    end
  end

  // ---------------- driver ----------------
  // Arms at the next edge, then drives trigger by enabled-cycle index k after arm
  // (pulse at k, or held from k when hold=1); pushes the expected write stream.
  task automatic run_capture(input int pos, input int k, input bit hold,
                             input bit gaps, output bit timed_out);
    int t, total, idx;
    t     = (hold && k <= pos) ? pos + 1 : k;
    total = (t - 1) + (DEPTH - pos);
    for (int i = 0; i < total; i++) exp_q.push_back(AW'(i));
    write_cnt = 0; done_seen = 0; saw_pretrig = 0; saw_post = 0;
    arm = 1'b1; abort = 1'b0; clk_enable = 1'b1;
    trigger = hold; trigger_position = AW'(pos);
    @(posedge clk); #1;
    arm = 1'b0;
    trigger_position = AW'($urandom_range(0, 15));
    idx = 0;
    timed_out = 1'b1;
    for (int n = 0; n < 400; n++) begin
      clk_enable = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (clk_enable) begin
        idx++;
        trigger = hold ? (idx >= k) : (idx == k);
      end else begin
        trigger = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (capture_done) begin
        timed_out = 1'b0;
        break;
      end
    end
    trigger = 1'b0; clk_enable = 1'b1;
    @(negedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; clk_enable = 1'b0; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
    trigger_position = '0;
    #2;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy_async: got %b want 0", busy); else pass_cnt++;
    clk_enable = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    total_cnt++; if (debug_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", debug_state, ST_IDLE); else pass_cnt++;
    total_cnt++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", wr_en); else pass_cnt++;
    total_cnt++; if (wr_addr !== 4'd0) $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); else pass_cnt++;
    total_cnt++; if (trigger_addr !== 4'd0) $display("FAIL reset_trigger_addr: got %0d want 0", trigger_addr); else pass_cnt++;
    total_cnt++; if (start_addr !== 4'd0) $display("FAIL reset_start_addr: got %0d want 0", start_addr); else pass_cnt++;
    total_cnt++; if (capture_done !== 1'b0) $display("FAIL reset_done: got %b want 0", capture_done); else pass_cnt++;
    reset = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_basic();
    bit to;
    run_capture(5, 9, 1'b0, 1'b0, to);
    total_cnt++; if (to) $display("FAIL basic_timeout: capture_done not seen, want done"); else pass_cnt++;
    total_cnt++; if (trigger_addr !== 4'd8) $display("FAIL basic_trigger_addr: got %0d want 8", trigger_addr); else pass_cnt++;
    total_cnt++; if (start_addr !== 4'd3) $display("FAIL basic_start_addr: got %0d want 3", start_addr); else pass_cnt++;
    total_cnt++; if (write_cnt != 19) $display("FAIL basic_writes: got %0d want 19", write_cnt); else pass_cnt++;
    total_cnt++; if (done_cyc - last_wr_cyc != 1) $display("FAIL basic_done_latency: got %0d want 1", done_cyc - last_wr_cyc); else pass_cnt++;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL basic_missing_writes: got %0d left want 0", exp_q.size()); else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_zero_pos();
    bit to;
    run_capture(0, 1, 1'b0, 1'b0, to);
    total_cnt++; if (to) $display("FAIL zero_timeout: capture_done not seen, want done"); else pass_cnt++;
    total_cnt++; if (trigger_addr !== 4'd0) $display("FAIL zero_trigger_addr: got %0d want 0", trigger_addr); else pass_cnt++;
    total_cnt++; if (start_addr !== 4'd0) $display("FAIL zero_start_addr: got %0d want 0", start_addr); else pass_cnt++;
    total_cnt++; if (write_cnt != 16) $display("FAIL zero_writes: got %0d want 16", write_cnt); else pass_cnt++;
    total_cnt++; if (saw_pretrig) $display("FAIL zero_no_pretrig: got 1 want 0"); else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_trigger_held();
    bit to;
    run_capture(4, 0, 1'b1, 1'b0, to);
    total_cnt++; if (to) $display("FAIL held_timeout: capture_done not seen, want done"); else pass_cnt++;
    total_cnt++; if (trigger_addr !== 4'd4) $display("FAIL held_trigger_addr: got %0d want 4", trigger_addr); else pass_cnt++;
    total_cnt++; if (start_addr !== 4'd0) $display("FAIL held_start_addr: got %0d want 0", start_addr); else pass_cnt++;
    total_cnt++; if (write_cnt != 16) $display("FAIL held_writes: got %0d want 16", write_cnt); else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_max_pos();
    bit to;
    run_capture(15, 36, 1'b0, 1'b0, to);
    total_cnt++; if (to) $display("FAIL maxpos_timeout: capture_done not seen, want done"); else pass_cnt++;
    total_cnt++; if (trigger_addr !== 4'd3) $display("FAIL maxpos_trigger_addr: got %0d want 3", trigger_addr); else pass_cnt++;
    total_cnt++; if (start_addr !== 4'd4) $display("FAIL maxpos_start_addr: got %0d want 4", start_addr); else pass_cnt++;
    total_cnt++; if (write_cnt != 36) $display("FAIL maxpos_writes: got %0d want 36", write_cnt); else pass_cnt++;
    total_cnt++; if (saw_post) $display("FAIL maxpos_no_posttrig: got 1 want 0"); else pass_cnt++;
    total_cnt++; if (done_cyc - last_wr_cyc != 1) $display("FAIL maxpos_done_latency: got %0d want 1", done_cyc - last_wr_cyc); else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_gaps();
    bit to;
    logic [AW-1:0] ref_trig, ref_start;
    int ref_writes;
    run_capture(6, 10, 1'b0, 1'b0, to);
    ref_trig = trigger_addr; ref_start = start_addr; ref_writes = write_cnt;
    total_cnt++; if (ref_trig !== 4'd9 || ref_start !== 4'd3) $display("FAIL gapfree_addrs: got %0d/%0d want 9/3", ref_trig, ref_start); else pass_cnt++;
    exp_q.delete();
    run_capture(6, 10, 1'b0, 1'b1, to);
    total_cnt++; if (to) $display("FAIL gaps_timeout: capture_done not seen, want done"); else pass_cnt++;
    total_cnt++; if (trigger_addr !== ref_trig) $display("FAIL gaps_trigger_addr: got %0d want %0d", trigger_addr, ref_trig); else pass_cnt++;
    total_cnt++; if (start_addr !== ref_start) $display("FAIL gaps_start_addr: got %0d want %0d", start_addr, ref_start); else pass_cnt++;
    total_cnt++; if (write_cnt != 19 || write_cnt != ref_writes) $display("FAIL gaps_writes: got %0d want 19 (gap-free %0d)", write_cnt, ref_writes); else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_abort();
    for (int i = 0; i < 6; i++) exp_q.push_back(AW'(i));
    write_cnt = 0;
    arm = 1'b1; clk_enable = 1'b1; trigger = 1'b0; trigger_position = 4'd2;
    @(posedge clk); #1;
    arm = 1'b0;
    for (int idx = 1; idx <= 5; idx++) begin
      trigger = (idx == 3);
      @(posedge clk); #1;
    end
    trigger = 1'b0;
    total_cnt++; if (debug_state !== ST_POSTTRIG) $display("FAIL abort_pre_state: got %0d want %0d", debug_state, ST_POSTTRIG); else pass_cnt++;
    abort = 1'b1; arm = 1'b1; trigger = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; arm = 1'b0; trigger = 1'b0;
    total_cnt++; if (debug_state !== ST_IDLE) $display("FAIL abort_state: got %0d want %0d", debug_state, ST_IDLE); else pass_cnt++;
    total_cnt++; if (wr_en !== 1'b0) $display("FAIL abort_wr_en: got %b want 0", wr_en); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else pass_cnt++;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total_cnt++; if (write_cnt != 6 || exp_q.size() != 0) $display("FAIL abort_writes: got %0d (left %0d) want 6 (left 0)", write_cnt, exp_q.size()); else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_reset_mid_pretrig();
    for (int i = 0; i < 3; i++) exp_q.push_back(AW'(i));
    write_cnt = 0;
    arm = 1'b1; clk_enable = 1'b1; trigger = 1'b0; trigger_position = 4'd10;
    @(posedge clk); #1;
    arm = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    total_cnt++; if (debug_state !== ST_PRETRIG) $display("FAIL rstmid_pre_state: got %0d want %0d", debug_state, ST_PRETRIG); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (debug_state !== ST_IDLE) $display("FAIL rstmid_state: got %0d want %0d", debug_state, ST_IDLE); else pass_cnt++;
    total_cnt++; if (wr_en !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_wr_en_busy: got %b/%b want 0/0", wr_en, busy); else pass_cnt++;
    total_cnt++; if (wr_addr !== 4'd0) $display("FAIL rstmid_wr_addr: got %0d want 0", wr_addr); else pass_cnt++;
    total_cnt++; if (trigger_addr !== 4'd0) $display("FAIL rstmid_trigger_addr: got %0d want 0", trigger_addr); else pass_cnt++;
    total_cnt++; if (start_addr !== 4'd0 || capture_done !== 1'b0) $display("FAIL rstmid_start_done: got %0d/%b want 0/0", start_addr, capture_done); else pass_cnt++;
    @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    total_cnt++; if (write_cnt != 3 || exp_q.size() != 0) $display("FAIL rstmid_writes: got %0d (left %0d) want 3 (left 0)", write_cnt, exp_q.size()); else pass_cnt++;
    exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_zero_pos();
    test_trigger_held();
    test_max_pos();
    test_gaps();
    test_abort();
    test_reset_mid_pretrig();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
